// File: rtl/imem_loader.sv
// imem_loader: parses a length-prefixed byte stream into 16-bit instruction-memory writes
module imem_loader #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic          reload,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [15:0]   imem_wdata,
    output logic          cpu_run,
    output logic          busy,
    output logic          err
);
    typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERR} state_t;
    state_t state, nextState;
    logic [7:0]  lenHi, hiByte;
    logic [15:0] wordCount;
    logic [16:0] wordIdx;
    logic [16:0] lenIn;
    logic        xfer, lastWord;
    assign xfer     = in_valid && in_ready;
    assign lenIn    = {1'b0, lenHi, in_data};
    assign lastWord = (wordIdx + 17'd1) == {1'b0, wordCount};
    // state register; reset abandons any load in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LEN_HI;
        else        state <= nextState;
    end
    // next-state: byte transfers advance the parser, WRITE always lasts one cycle
    always_comb begin
        nextState = state;
        case (state)
            LEN_HI:  if (xfer) nextState = LEN_LO;
            LEN_LO:  if (xfer) nextState = (lenIn == 17'd0) ? DONE : (lenIn > 17'(DEPTH)) ? ERR : DATA_HI;
            DATA_HI: if (xfer) nextState = DATA_LO;
            DATA_LO: if (xfer) nextState = WRITE;
            WRITE:   nextState = lastWord ? DONE : DATA_HI;
            DONE:    if (reload) nextState = LEN_HI;
            default: nextState = state;
        endcase
    end
    // captured length/bytes, word index, and the held write address/data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lenHi      <= '0;
            hiByte     <= '0;
            wordCount  <= '0;
            wordIdx    <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            if (state == LEN_HI && xfer) lenHi <= in_data;
            if (state == LEN_LO && xfer) wordCount <= {lenHi, in_data};
            if (state == DATA_HI && xfer) hiByte <= in_data;
            if (state == DATA_LO && xfer) begin
                imem_addr  <= wordIdx[AW-1:0];
                imem_wdata <= {hiByte, in_data};
            end
            if (state == WRITE) wordIdx <= wordIdx + 17'd1;
            if (state == DONE && reload) wordIdx <= '0;
        end
    end
    // status and strobe outputs decode directly from the state
    always_comb begin
        in_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA_HI) || (state == DATA_LO);
        busy     = (state == LEN_LO) || (state == DATA_HI) || (state == DATA_LO) || (state == WRITE);
        imem_we  = state == WRITE;
        cpu_run  = state == DONE;
        err      = state == ERR;
    end
endmodule
